// File: rtl/ssio_sdr_word_align.sv
// Bit-to-word aligner for the SDR serial input: hunts for the sync word, verifies framing,
// then emits MSB-first aligned words and drops lock after a run of non-sync words.
module ssio_sdr_word_align #(
  parameter int unsigned              DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]    SYNC_WORD    = 8'hBC,
  parameter int unsigned              LOCK_COUNT   = 3,
  parameter int unsigned              SYNC_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  input_d,
  input  logic                  resync,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  locked,
  output logic [7:0]            lock_loss_count
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TW = (SYNC_TIMEOUT < 1) ? 1 : $clog2(SYNC_TIMEOUT + 1);

  localparam logic [BW-1:0] LastBit    = BW'(DATA_WIDTH - 1);
  localparam logic [MW-1:0] LockMax    = MW'(LOCK_COUNT);
  localparam logic [TW-1:0] TimeoutMax = TW'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [MW-1:0]         match_cnt_q;
  logic [TW-1:0]         timeout_cnt_q;

  logic [DATA_WIDTH-1:0] window;
  logic                  sync_hit;
  logic                  boundary;
  logic [BW-1:0]         bit_next;
  logic [MW-1:0]         match_inc;
  logic [TW-1:0]         timeout_inc;
  logic                  timeout_hit;

  // Window holds the newest W bits including the one currently on input_d.
  always_comb begin
    window      = {shift_q, input_d};
    sync_hit    = (window == SYNC_WORD);
    boundary    = (bit_cnt_q == LastBit);
    bit_next    = boundary ? '0 : bit_cnt_q + BW'(1);
    match_inc   = match_cnt_q + MW'(1);
    timeout_inc = timeout_cnt_q + TW'(1);
    timeout_hit = (SYNC_TIMEOUT != 0) && (timeout_inc == TimeoutMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StHunt;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      match_cnt_q     <= '0;
      timeout_cnt_q   <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tuser    <= 1'b0;
      locked          <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      shift_q       <= window[DATA_WIDTH-2:0];
      m_axis_tvalid <= 1'b0;
      if (resync) begin
        state_q       <= StHunt;
        match_cnt_q   <= '0;
        timeout_cnt_q <= '0;
        locked        <= 1'b0;
      end else begin
        unique case (state_q)
          StHunt: begin
            if (sync_hit) begin
              bit_cnt_q   <= '0;
              match_cnt_q <= MW'(1);
              if (LOCK_COUNT == 1) begin
                state_q       <= StLocked;
                timeout_cnt_q <= '0;
                locked        <= 1'b1;
              end else begin
                state_q <= StVerify;
              end
            end
          end
          StVerify: begin
            bit_cnt_q <= bit_next;
            if (boundary) begin
              if (sync_hit) begin
                match_cnt_q <= match_inc;
                if (match_inc == LockMax) begin
                  state_q       <= StLocked;
                  timeout_cnt_q <= '0;
                  locked        <= 1'b1;
                end
              end else begin
                state_q     <= StHunt;
                match_cnt_q <= '0;
              end
            end
          end
          StLocked: begin
            bit_cnt_q <= bit_next;
            if (boundary) begin
              m_axis_tdata  <= window;
              m_axis_tvalid <= 1'b1;
              m_axis_tuser  <= sync_hit;
              if (sync_hit) begin
                timeout_cnt_q <= '0;
              end else if (timeout_hit) begin
                // The word that exhausts the timeout is still emitted above.
                state_q       <= StHunt;
                match_cnt_q   <= '0;
                timeout_cnt_q <= '0;
                locked        <= 1'b0;
                if (lock_loss_count != 8'hFF) begin
                  lock_loss_count <= lock_loss_count + 8'd1;
                end
              end else begin
                timeout_cnt_q <= timeout_inc;
              end
            end
          end
          default: begin
            state_q <= StHunt;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssio_sdr_word_align.sv
// Directed bench for ssio_sdr_word_align: word-level vector table plus multi-cycle corner cases.
module tb_ssio_sdr_word_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       input_d = 1'b0;
  logic       resync = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tuser;
  logic       locked;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad = 0;

  // Per-word observations collected by send_word.
  int         w_vcnt;
  logic [7:0] w_tdata;
  logic       w_tuser;
  logic       w_locked;
  logic       w_prelock;

  ssio_sdr_word_align #(
    .DATA_WIDTH  (8),
    .SYNC_WORD   (8'hBC),
    .LOCK_COUNT  (3),
    .SYNC_TIMEOUT(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_d        (input_d),
    .resync         (resync),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tuser   (m_axis_tuser),
    .locked         (locked),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    int         exp_valid;
    logic [7:0] exp_data;
    logic       exp_user;
    logic       exp_locked;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_bit(input logic b, input logic rs);
    input_d = b;
    resync  = rs;
    @(posedge clk);
    #1;
    if (m_axis_tvalid) begin
      w_vcnt++;
      w_tdata = m_axis_tdata;
      w_tuser = m_axis_tuser;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit rs_last);
    w_vcnt = 0;
    for (int i = 7; i >= 0; i--) begin
      step_bit(w[i], rs_last && (i == 0));
      if (i == 1) w_prelock = locked;
    end
    resync   = 1'b0;
    w_locked = locked;
  endtask

  task automatic do_reset();
    input_d = 1'b0;
    resync  = 1'b0;
    rst_n   = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lock3(input string name);
    send_word(8'hBC, 1'b0);
    send_word(8'hBC, 1'b0);
    send_word(8'hBC, 1'b0);
    check({name, "_locked"}, {31'd0, w_locked}, 32'd1);
  endtask

  initial begin
    int vsum;
    logic [7:0] loss_before;

    vecs[0]  = '{8'hBC, 0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'hBC, 0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'hBC, 0, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{8'hA5, 1, 8'hA5, 1'b0, 1'b1};
    vecs[4]  = '{8'hBC, 1, 8'hBC, 1'b1, 1'b1};
    vecs[5]  = '{8'h3C, 1, 8'h3C, 1'b0, 1'b1};
    vecs[6]  = '{8'h00, 1, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{8'hFF, 1, 8'hFF, 1'b0, 1'b1};
    // 0B,C0 carries a misaligned BC that must be ignored while locked.
    vecs[8]  = '{8'h0B, 1, 8'h0B, 1'b0, 1'b1};
    vecs[9]  = '{8'hC0, 1, 8'hC0, 1'b0, 1'b1};
    vecs[10] = '{8'h5A, 1, 8'h5A, 1'b0, 1'b1};
    vecs[11] = '{8'hBC, 1, 8'hBC, 1'b1, 1'b1};

    #2;
    do_reset();
    check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tuser", {31'd0, m_axis_tuser}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_loss", {24'd0, lock_loss_count}, 32'd0);

    // Vector table from reset.
    for (int i = 0; i < 12; i++) begin
      send_word(vecs[i].word, 1'b0);
      check($sformatf("vec%0d_valid", i), w_vcnt, vecs[i].exp_valid);
      check($sformatf("vec%0d_locked", i), {31'd0, w_locked}, {31'd0, vecs[i].exp_locked});
      if (vecs[i].exp_valid != 0) begin
        check($sformatf("vec%0d_tdata", i), {24'd0, w_tdata}, {24'd0, vecs[i].exp_data});
        check($sformatf("vec%0d_tuser", i), {31'd0, w_tuser}, {31'd0, vecs[i].exp_user});
      end
    end

    // Lock acquisition at several bit offsets.
    for (int k = 0; k < 3; k++) begin
      int off;
      off = (k == 0) ? 0 : ((k == 1) ? 3 : 7);
      do_reset();
      w_vcnt = 0;
      for (int j = 0; j < off; j++) step_bit(1'b0, 1'b0);
      send_word(8'hBC, 1'b0);
      vsum = w_vcnt;
      send_word(8'hBC, 1'b0);
      vsum += w_vcnt;
      send_word(8'hBC, 1'b0);
      vsum += w_vcnt;
      check($sformatf("off%0d_novalid", off), vsum, 0);
      check($sformatf("off%0d_prelock", off), {31'd0, w_prelock}, 32'd0);
      check($sformatf("off%0d_lock", off), {31'd0, w_locked}, 32'd1);
      send_word(8'hA5, 1'b0);
      check($sformatf("off%0d_a5_valid", off), w_vcnt, 1);
      check($sformatf("off%0d_a5_tdata", off), {24'd0, w_tdata}, 32'hA5);
      check($sformatf("off%0d_a5_tuser", off), {31'd0, w_tuser}, 32'd0);
    end

    // VERIFY failure then relock.
    do_reset();
    vsum = 0;
    send_word(8'hBC, 1'b0);
    vsum += w_vcnt;
    send_word(8'hBC, 1'b0);
    vsum += w_vcnt;
    send_word(8'h3C, 1'b0);
    vsum += w_vcnt;
    check("vfail_novalid", vsum, 0);
    check("vfail_unlocked", {31'd0, w_locked}, 32'd0);
    send_word(8'hBC, 1'b0);
    send_word(8'hBC, 1'b0);
    check("vfail_still_unlocked", {31'd0, w_locked}, 32'd0);
    send_word(8'hBC, 1'b0);
    check("vfail_relock", {31'd0, w_locked}, 32'd1);

    // Timeout: 16 zero words, all emitted, lock dropped after the 16th.
    vsum = 0;
    for (int j = 0; j < 16; j++) begin
      send_word(8'h00, 1'b0);
      vsum += w_vcnt;
      if (j == 14) check("to_locked_15", {31'd0, w_locked}, 32'd1);
    end
    check("to_emitted", vsum, 16);
    check("to_tuser", {31'd0, w_tuser}, 32'd0);
    check("to_unlocked", {31'd0, w_locked}, 32'd0);
    check("to_loss1", {24'd0, lock_loss_count}, 32'd1);

    // 15 zeros then a sync word keeps lock and restarts the timeout.
    lock3("to2");
    for (int j = 0; j < 15; j++) send_word(8'h00, 1'b0);
    send_word(8'hBC, 1'b0);
    check("to2_bc_tuser", {31'd0, w_tuser}, 32'd1);
    check("to2_held", {31'd0, w_locked}, 32'd1);
    for (int j = 0; j < 15; j++) send_word(8'h00, 1'b0);
    check("to2_held15", {31'd0, w_locked}, 32'd1);
    check("to2_loss_same", {24'd0, lock_loss_count}, 32'd1);
    send_word(8'h00, 1'b0);
    check("to2_drop", {31'd0, w_locked}, 32'd0);
    check("to2_loss2", {24'd0, lock_loss_count}, 32'd2);

    // resync coincident with a word boundary.
    lock3("rs");
    send_word(8'h5A, 1'b0);
    loss_before = lock_loss_count;
    send_word(8'hA5, 1'b1);
    check("rs_novalid", w_vcnt, 0);
    check("rs_unlocked", {31'd0, w_locked}, 32'd0);
    check("rs_tdata_held", {24'd0, m_axis_tdata}, 32'h5A);
    check("rs_loss", {24'd0, lock_loss_count}, {24'd0, loss_before});
    lock3("rs_relock");

    // Asynchronous reset mid-word while locked.
    step_bit(1'b1, 1'b0);
    step_bit(1'b0, 1'b0);
    step_bit(1'b1, 1'b0);
    step_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_loss", {24'd0, lock_loss_count}, 32'd0);
    check("arst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("arst_tuser", {31'd0, m_axis_tuser}, 32'd0);
    #15;
    @(negedge clk);
    rst_n = 1'b1;
    w_vcnt = 0;
    step_bit(1'b0, 1'b0);
    step_bit(1'b1, 1'b0);
    step_bit(1'b0, 1'b0);
    step_bit(1'b1, 1'b0);
    vsum = w_vcnt;
    send_word(8'hBC, 1'b0);
    vsum += w_vcnt;
    send_word(8'hBC, 1'b0);
    vsum += w_vcnt;
    check("arst_novalid", vsum, 0);
    check("arst_not_locked", {31'd0, w_locked}, 32'd0);
    send_word(8'hBC, 1'b0);
    check("arst_relock", {31'd0, w_locked}, 32'd1);

    // Saturation of the lock-loss counter.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < 3; j++) send_word(8'hBC, 1'b0);
      for (int j = 0; j < 16; j++) send_word(8'h00, 1'b0);
      if (n == 9) check("sat_loss10", {24'd0, lock_loss_count}, 32'd10);
    end
    check("sat_loss255", {24'd0, lock_loss_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
